// File: rtl/fifo_pkg.sv
// fifo_pkg: shared Gray/binary helpers and depth derivation for the async FIFO pointer controllers.
// The helpers work on any width up to MAXW because the input is zero-extended.
package fifo_pkg;
    localparam int MAXW = 17;

    function automatic int fifo_depth(input int addrsize);
        return 1 << addrsize;
    endfunction

    function automatic logic [MAXW-1:0] bin2gray(input logic [MAXW-1:0] b);
        return (b >> 1) ^ b;
    endfunction

    function automatic logic [MAXW-1:0] gray2bin(input logic [MAXW-1:0] g);
        logic [MAXW-1:0] b;
        b[MAXW-1] = g[MAXW-1];
        for (int i = MAXW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction
endpackage

// File: rtl/gray2bin_conv.sv
// gray2bin_conv: combinational Gray-to-binary converter (XOR prefix from the MSB down).
module gray2bin_conv #(
    parameter int W = 4
) (
    input  logic [W-1:0] i_gray,
    output logic [W-1:0] o_bin
);
    for (genvar i = 0; i < W; i++) begin : g_bit
        assign o_bin[i] = ^i_gray[W-1:i];
    end
endmodule

// File: rtl/wptr_full_ctrl.sv
// wptr_full_ctrl: write-domain pointer and status controller for the async FIFO.
// Keeps binary/Gray write pointers and derives full, almost-full, occupancy and sticky overflow.
module wptr_full_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDRSIZE     = 3,
    parameter int AFULL_THRESH = 2
) (
    input  logic                i_wclk,
    input  logic                i_wrst_n,
    input  logic                i_winc,
    input  logic [ADDRSIZE:0]   i_wq2_rptr,
    input  logic                i_ovf_clr,
    output logic [ADDRSIZE-1:0] o_waddr,
    output logic [ADDRSIZE:0]   o_wptr,
    output logic                o_wfull,
    output logic                o_walmost_full,
    output logic [ADDRSIZE:0]   o_wcount,
    output logic                o_woverflow
);
    localparam int DEPTH = fifo_depth(ADDRSIZE);
    localparam int PW    = ADDRSIZE + 1;

    logic [ADDRSIZE:0] r_wbin, r_wptr, r_wcount;
    logic              r_wfull, r_walmost_full, r_woverflow;
    logic [ADDRSIZE:0] w_rbin, w_wbinnext, w_wgraynext, w_wcount_next;
    logic              w_wpush, w_wfull_next, w_walmost_full_next;

    gray2bin_conv #(.W(PW)) u_g2b (
        .i_gray (i_wq2_rptr),
        .o_bin  (w_rbin)
    );

    assign w_wpush             = i_winc & ~r_wfull;
    assign w_wbinnext          = r_wbin + PW'(w_wpush);
    assign w_wgraynext         = PW'(bin2gray(MAXW'(w_wbinnext)));
    // Full: write pointer one lap ahead, i.e. Gray MSBs inverted and the rest equal.
    assign w_wfull_next        = w_wgraynext == {~i_wq2_rptr[ADDRSIZE:ADDRSIZE-1], i_wq2_rptr[ADDRSIZE-2:0]};
    assign w_wcount_next       = w_wbinnext - w_rbin;
    assign w_walmost_full_next = (DEPTH - int'(w_wcount_next)) <= AFULL_THRESH;

    always_ff @(posedge i_wclk or negedge i_wrst_n) begin
        if (!i_wrst_n) begin
            r_wbin          <= '0;
            r_wptr          <= '0;
            r_wfull         <= 1'b0;
            r_walmost_full  <= 1'b0;
            r_wcount        <= '0;
            r_woverflow     <= 1'b0;
        end else begin
            r_wbin          <= w_wbinnext;
            r_wptr          <= w_wgraynext;
            r_wfull         <= w_wfull_next;
            r_walmost_full  <= w_walmost_full_next;
            r_wcount        <= w_wcount_next;
            r_woverflow     <= (i_winc & r_wfull) | (r_woverflow & ~i_ovf_clr);
        end
    end

    assign o_waddr        = r_wbin[ADDRSIZE-1:0];
    assign o_wptr         = r_wptr;
    assign o_wfull        = r_wfull;
    assign o_walmost_full = r_walmost_full;
    assign o_wcount       = r_wcount;
    assign o_woverflow    = r_woverflow;
endmodule

// File: tb/tb_wptr_full_ctrl.sv
// tb_wptr_full_ctrl: directed self-checking bench for wptr_full_ctrl with ADDRSIZE=3, AFULL_THRESH=2.
module tb_wptr_full_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       winc = 1'b0;
    logic [3:0] rptr = 4'd0;
    logic       ovf_clr = 1'b0;
    logic [2:0] waddr;
    logic [3:0] wptr;
    logic       wfull, walmost_full, woverflow;
    logic [3:0] wcount;
    int         n_tests = 0;
    int         n_fail = 0;
    logic [3:0] gtab [0:15] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                                4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};

    wptr_full_ctrl #(.ADDRSIZE(3), .AFULL_THRESH(2)) dut (
        .i_wclk         (clk),
        .i_wrst_n       (rst_n),
        .i_winc         (winc),
        .i_wq2_rptr     (rptr),
        .i_ovf_clr      (ovf_clr),
        .o_waddr        (waddr),
        .o_wptr         (wptr),
        .o_wfull        (wfull),
        .o_walmost_full (walmost_full),
        .o_wcount       (wcount),
        .o_woverflow    (woverflow)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({waddr, wptr, wfull, walmost_full, wcount, woverflow} !== 14'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want all zero", {waddr, wptr, wfull, walmost_full, wcount, woverflow});
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        n_tests++;
        if ({waddr, wptr, wcount, wfull} !== 12'd0) begin
            n_fail++;
            $display("FAIL idle_hold: got waddr=%0d wptr=%0d wcount=%0d wfull=%0d want 0", waddr, wptr, wcount, wfull);
        end
    endtask

    task automatic test_fill();
        winc = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            n_tests++;
            if (wcount !== 4'(k) || waddr !== 3'(k % 8) || wptr !== gtab[k] ||
                walmost_full !== (k >= 6) || wfull !== (k == 8)) begin
                n_fail++;
                $display("FAIL fill_%0d: got wcount=%0d waddr=%0d wptr=%b af=%0d full=%0d want %0d %0d %b %0d %0d",
                         k, wcount, waddr, wptr, walmost_full, wfull, k, k % 8, gtab[k], k >= 6, k == 8);
            end
        end
        winc = 1'b0;
    endtask

    task automatic test_overflow();
        winc = 1'b1;
        @(negedge clk);
        winc = 1'b0;
        n_tests++;
        if (woverflow !== 1'b1 || wcount !== 4'd8 || wptr !== 4'b1100 || waddr !== 3'd0 || wfull !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_set: got ovf=%0d wcount=%0d wptr=%b waddr=%0d full=%0d want 1 8 1100 0 1",
                     woverflow, wcount, wptr, waddr, wfull);
        end
        @(negedge clk);
        n_tests++;
        if (woverflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_sticky: got %0d want 1", woverflow);
        end
        winc = 1'b1;
        ovf_clr = 1'b1;
        @(negedge clk);
        n_tests++;
        if (woverflow !== 1'b1 || wcount !== 4'd8 || wptr !== 4'b1100) begin
            n_fail++;
            $display("FAIL ovf_set_wins: got ovf=%0d wcount=%0d wptr=%b want 1 8 1100", woverflow, wcount, wptr);
        end
        winc = 1'b0;
        @(negedge clk);
        ovf_clr = 1'b0;
        n_tests++;
        if (woverflow !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clear: got %0d want 0", woverflow);
        end
    endtask

    task automatic test_drain_wrap();
        for (int k = 1; k <= 8; k++) begin
            rptr = gtab[k];
            @(negedge clk);
            n_tests++;
            if (wcount !== 4'(8 - k) || wfull !== 1'b0 || walmost_full !== (k <= 2)) begin
                n_fail++;
                $display("FAIL drain_%0d: got wcount=%0d full=%0d af=%0d want %0d 0 %0d",
                         k, wcount, wfull, walmost_full, 8 - k, k <= 2);
            end
        end
        winc = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            n_tests++;
            if (wcount !== 4'(k) || waddr !== 3'(k % 8) || wptr !== gtab[(8 + k) % 16] || wfull !== (k == 8)) begin
                n_fail++;
                $display("FAIL wrap_%0d: got wcount=%0d waddr=%0d wptr=%b full=%0d want %0d %0d %b %0d",
                         k, wcount, waddr, wptr, wfull, k, k % 8, gtab[(8 + k) % 16], k == 8);
            end
        end
        winc = 1'b0;
    endtask

    task automatic test_simultaneous();
        for (int k = 9; k <= 11; k++) begin
            rptr = gtab[k];
            @(negedge clk);
            n_tests++;
            if (wcount !== 4'(16 - k)) begin
                n_fail++;
                $display("FAIL sim_prep_%0d: got wcount=%0d want %0d", k, wcount, 16 - k);
            end
        end
        winc = 1'b1;
        rptr = gtab[12];
        @(negedge clk);
        winc = 1'b0;
        n_tests++;
        if (wcount !== 4'd5 || walmost_full !== 1'b0 || wfull !== 1'b0 || waddr !== 3'd1) begin
            n_fail++;
            $display("FAIL simultaneous: got wcount=%0d af=%0d full=%0d waddr=%0d want 5 0 0 1",
                     wcount, walmost_full, wfull, waddr);
        end
    endtask

    task automatic test_async_reset();
        rptr = gtab[13];
        @(negedge clk);
        n_tests++;
        if (wcount !== 4'd4) begin
            n_fail++;
            $display("FAIL arst_prep: got wcount=%0d want 4", wcount);
        end
        winc = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({waddr, wptr, wfull, walmost_full, wcount, woverflow} !== 14'd0) begin
            n_fail++;
            $display("FAIL arst_immediate: got %b want all zero", {waddr, wptr, wfull, walmost_full, wcount, woverflow});
        end
        rptr = 4'd0;
        @(negedge clk);
        n_tests++;
        if ({waddr, wptr, wcount} !== 11'd0) begin
            n_fail++;
            $display("FAIL arst_hold: got waddr=%0d wptr=%0d wcount=%0d want 0", waddr, wptr, wcount);
        end
        rst_n = 1'b1;
        @(negedge clk);
        winc = 1'b0;
        n_tests++;
        if (wcount !== 4'd1 || waddr !== 3'd1 || wptr !== 4'd1) begin
            n_fail++;
            $display("FAIL arst_resume: got wcount=%0d waddr=%0d wptr=%b want 1 1 0001", wcount, waddr, wptr);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_drain_wrap();
        test_simultaneous();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
